// File: rtl/cache_fsm_l2c_if.sv
// L1c-facing and L3-facing handshake bundle of the L2c controller.
// slave is the controller's view, master the surrounding system's.
interface cache_fsm_l2c_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_WIDTH   = 128
);
  logic                     read_from_L2c_request;
  logic                     write_to_L2c_request;
  logic                     write_back_to_L2c_request;
  logic [ADDRESS_WIDTH-1:0] cache_L2c_memory_address;
  logic [DATA_WIDTH-1:0]    cache_1c_write_data_to_L2c;
  logic [BLOCK_WIDTH-1:0]   write_back_to_L2c_data;
  logic                     L2c_ready;
  logic [BLOCK_WIDTH-1:0]   write_data_to_L1c_from_L2c;
  logic                     write_to_L2c_verified;
  logic                     write_back_to_L2c_verified;
  logic                     L2c_cache_hit;
  logic                     L2c_cache_miss;
  logic                     read_from_L3_request;
  logic                     write_back_to_L3_request;
  logic [ADDRESS_WIDTH-1:0] cache_L3_memory_address;
  logic [BLOCK_WIDTH-1:0]   write_back_to_L3_data;
  logic                     L3_ready;
  logic [BLOCK_WIDTH-1:0]   read_data_from_L3;
  logic                     write_back_to_L3_verified;

  modport slave (
    input  read_from_L2c_request, write_to_L2c_request,
    input  write_back_to_L2c_request, cache_L2c_memory_address,
    input  cache_1c_write_data_to_L2c, write_back_to_L2c_data,
    output L2c_ready, write_data_to_L1c_from_L2c,
    output write_to_L2c_verified, write_back_to_L2c_verified,
    output L2c_cache_hit, L2c_cache_miss,
    output read_from_L3_request, write_back_to_L3_request,
    output cache_L3_memory_address, write_back_to_L3_data,
    input  L3_ready, read_data_from_L3, write_back_to_L3_verified
  );

  modport master (
    output read_from_L2c_request, write_to_L2c_request,
    output write_back_to_L2c_request, cache_L2c_memory_address,
    output cache_1c_write_data_to_L2c, write_back_to_L2c_data,
    input  L2c_ready, write_data_to_L1c_from_L2c,
    input  write_to_L2c_verified, write_back_to_L2c_verified,
    input  L2c_cache_hit, L2c_cache_miss,
    input  read_from_L3_request, write_back_to_L3_request,
    input  cache_L3_memory_address, write_back_to_L3_data,
    output L3_ready, read_data_from_L3, write_back_to_L3_verified
  );
endinterface

// File: rtl/cache_fsm_l2c.sv
// L2c controller: 2-way set-associative, write-back/write-allocate,
// one LRU bit per set, L3 write-back and fetch handshakes.
module cache_fsm_l2c #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_WIDTH   = 128,
  parameter int L2_NUM_SETS   = 16,
  parameter int OFFSET_LSB    = 2
) (
  input logic             clk,
  input logic             reset,
  cache_fsm_l2c_if.slave  bus
);
  localparam int IW = $clog2(L2_NUM_SETS);
  localparam int TW = 30 - IW - 4;

  typedef enum logic [2:0] {
    IDLE, COMPARE, WRITE_BACK_L3, ALLOCATE, RESPOND
  } state_t;
  typedef enum logic [1:0] {REQ_RD, REQ_WR, REQ_WB} req_t;

  state_t state, state_n;
  req_t   req_q, req_sel;

  logic [2:0]             prev_q, req_now, rise;
  logic [29:OFFSET_LSB]   addr_q;
  logic [DATA_WIDTH-1:0]  word_q;
  logic [BLOCK_WIDTH-1:0] blk_q, out_q, merged;
  logic                   way_q;

  logic [L2_NUM_SETS-1:0][1:0] valid, dirty;
  logic [L2_NUM_SETS-1:0]      lru;
  logic [TW-1:0]          tag_mem  [L2_NUM_SETS][2];
  logic [BLOCK_WIDTH-1:0] data_mem [L2_NUM_SETS][2];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [1:0]    off;
  logic          hit0, hit1, hit, hit_way, victim, sel_way;
  logic          unused_addr;

  assign unused_addr = ^{
    bus.cache_L2c_memory_address[ADDRESS_WIDTH-1 -: 2],
    bus.cache_L2c_memory_address[OFFSET_LSB-1:0]};

  assign idx = addr_q[IW+3:4];
  assign tag = addr_q[29:IW+4];
  assign off = addr_q[OFFSET_LSB+1:OFFSET_LSB];

  assign req_now = {bus.write_back_to_L2c_request,
                    bus.write_to_L2c_request,
                    bus.read_from_L2c_request};
  assign rise = req_now & ~prev_q;

  always_comb begin
    req_sel = REQ_RD;
    priority case (1'b1)
      rise[2]: req_sel = REQ_WB;
      rise[1]: req_sel = REQ_WR;
      default: req_sel = REQ_RD;
    endcase
  end

  assign hit0    = valid[idx][0] && tag_mem[idx][0] == tag;
  assign hit1    = valid[idx][1] && tag_mem[idx][1] == tag;
  assign hit     = hit0 | hit1;
  assign hit_way = ~hit0;
  // Fill invalid ways in order before displacing the LRU way.
  assign victim  = !valid[idx][0] ? 1'b0 :
                   !valid[idx][1] ? 1'b1 : lru[idx];
  assign sel_way = hit ? hit_way : victim;

  always_comb begin
    merged = data_mem[idx][way_q];
    merged[off*DATA_WIDTH +: DATA_WIDTH] = word_q;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (|rise) state_n = COMPARE;
      COMPARE:
        if (hit)
          state_n = RESPOND;
        else if (valid[idx][victim] && dirty[idx][victim])
          state_n = WRITE_BACK_L3;
        else
          state_n = ALLOCATE;
      WRITE_BACK_L3:
        if (bus.write_back_to_L3_verified) state_n = ALLOCATE;
      ALLOCATE: if (bus.L3_ready) state_n = RESPOND;
      RESPOND:  state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
      valid  <= '0;
      dirty  <= '0;
      lru    <= '0;
      out_q  <= '0;
      req_q  <= REQ_RD;
      way_q  <= 1'b0;
      addr_q <= '0;
      word_q <= '0;
      blk_q  <= '0;
    end else begin
      prev_q <= req_now;
      if (state == IDLE && |rise) begin
        req_q  <= req_sel;
        addr_q <= bus.cache_L2c_memory_address[29:OFFSET_LSB];
        word_q <= bus.cache_1c_write_data_to_L2c;
        blk_q  <= bus.write_back_to_L2c_data;
      end
      unique case (state)
        COMPARE: begin
          way_q <= sel_way;
          if (hit && req_q == REQ_RD)
            out_q <= data_mem[idx][hit_way];
        end
        WRITE_BACK_L3:
          if (bus.write_back_to_L3_verified)
            dirty[idx][way_q] <= 1'b0;
        ALLOCATE:
          if (bus.L3_ready) begin
            valid[idx][way_q] <= 1'b1;
            dirty[idx][way_q] <= 1'b0;
            if (req_q == REQ_RD) out_q <= bus.read_data_from_L3;
          end
        RESPOND: begin
          lru[idx] <= ~way_q;
          if (req_q != REQ_RD) dirty[idx][way_q] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ALLOCATE && bus.L3_ready) begin
        tag_mem[idx][way_q]  <= tag;
        data_mem[idx][way_q] <= bus.read_data_from_L3;
      end else if (state == RESPOND && req_q == REQ_WR) begin
        data_mem[idx][way_q] <= merged;
      end else if (state == RESPOND && req_q == REQ_WB) begin
        data_mem[idx][way_q] <= blk_q;
      end
    end
  end

  assign bus.write_data_to_L1c_from_L2c = out_q;

  always_comb begin
    bus.L2c_ready                  = 1'b0;
    bus.write_to_L2c_verified      = 1'b0;
    bus.write_back_to_L2c_verified = 1'b0;
    bus.L2c_cache_hit              = 1'b0;
    bus.L2c_cache_miss             = 1'b0;
    bus.read_from_L3_request       = 1'b0;
    bus.write_back_to_L3_request   = 1'b0;
    bus.cache_L3_memory_address    = '0;
    bus.write_back_to_L3_data      = '0;
    unique case (state)
      COMPARE: begin
        bus.L2c_cache_hit  = hit;
        bus.L2c_cache_miss = ~hit;
      end
      WRITE_BACK_L3: begin
        bus.write_back_to_L3_request = 1'b1;
        bus.cache_L3_memory_address  =
          {2'b00, tag_mem[idx][way_q], idx, 4'b0};
        bus.write_back_to_L3_data    = data_mem[idx][way_q];
      end
      ALLOCATE: begin
        bus.read_from_L3_request    = 1'b1;
        bus.cache_L3_memory_address = {2'b00, addr_q[29:4], 4'b0};
      end
      RESPOND: begin
        bus.L2c_ready                  = req_q == REQ_RD;
        bus.write_to_L2c_verified      = req_q == REQ_WR;
        bus.write_back_to_L2c_verified = req_q == REQ_WB;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cache_fsm_l2c.sv
// Transaction-level model of the L2c controller checked every cycle,
// directed scenarios followed by randomized request streams.
module tb_cache_fsm_l2c;
  logic clk = 0;
  logic reset;
  always #5 clk = ~clk;

  cache_fsm_l2c_if bus ();
  cache_fsm_l2c dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  logic         exp_hit, exp_miss, exp_rdy, exp_wv, exp_wbv;
  logic         exp_rd3, exp_wb3;
  logic [31:0]  exp_addr3;
  logic [127:0] exp_data3, exp_blk;

  bit           m_valid [2][16];
  bit           m_dirty [2][16];
  logic [21:0]  m_tag   [2][16];
  logic [127:0] m_data  [2][16];
  bit           m_lru   [16];
  logic [127:0] mem [logic [31:0]];

  int n_hit = 0, n_miss = 0, n_rdy = 0, n_wv = 0, n_wbv = 0, cyc_n = 0;
  int last_wb_cyc = 0, last_fetch_cyc = 0;
  logic [31:0]  obs_fetch = 0, obs_wb = 0;
  logic [127:0] obs_blk = 0, obs_wbdata = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("hit", bus.L2c_cache_hit, exp_hit);
      chk("miss", bus.L2c_cache_miss, exp_miss);
      chk("ready", bus.L2c_ready, exp_rdy);
      chk("wr_verified", bus.write_to_L2c_verified, exp_wv);
      chk("wb_verified", bus.write_back_to_L2c_verified, exp_wbv);
      chk("l3_read_req", bus.read_from_L3_request, exp_rd3);
      chk("l3_wb_req", bus.write_back_to_L3_request, exp_wb3);
      chk("l3_addr", bus.cache_L3_memory_address, exp_addr3);
      chk("l3_wb_data", bus.write_back_to_L3_data, exp_data3);
      chk("l1_block", bus.write_data_to_L1c_from_L2c, exp_blk);
    end
    if (bus.L2c_cache_hit) n_hit++;
    if (bus.L2c_cache_miss) n_miss++;
    if (bus.L2c_ready) begin
      n_rdy++;
      obs_blk = bus.write_data_to_L1c_from_L2c;
    end
    if (bus.write_to_L2c_verified) n_wv++;
    if (bus.write_back_to_L2c_verified) n_wbv++;
    if (bus.read_from_L3_request) begin
      obs_fetch = bus.cache_L3_memory_address;
      last_fetch_cyc = cyc_n;
    end
    if (bus.write_back_to_L3_request) begin
      obs_wb = bus.cache_L3_memory_address;
      obs_wbdata = bus.write_back_to_L3_data;
      last_wb_cyc = cyc_n;
    end
  end

  function automatic logic [127:0] mem_get(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = {$urandom, $urandom, $urandom, $urandom};
    return mem[a];
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 16; s++) begin
        m_valid[w][s] = 0;
        m_dirty[w][s] = 0;
      end
    for (int s = 0; s < 16; s++) m_lru[s] = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    reset = 0;
    bus.read_from_L2c_request = 0;
    bus.write_to_L2c_request = 0;
    bus.write_back_to_L2c_request = 0;
    bus.L3_ready = 0;
    bus.write_back_to_L3_verified = 0;
    bus.read_data_from_L3 = {$urandom, $urandom, $urandom, $urandom};
    exp_hit = 0; exp_miss = 0; exp_rdy = 0; exp_wv = 0; exp_wbv = 0;
    exp_rd3 = 0; exp_wb3 = 0; exp_addr3 = 0; exp_data3 = 0;
  endtask

  task automatic txn(input bit rd, input bit wr, input bit wbk,
                     input logic [31:0] a, input logic [31:0] w,
                     input logic [127:0] b, input bit spur, input bit rstm);
    int t, i, nw;
    logic [21:0] tg;
    bit h, wy;
    logic [31:0] wa, fa;
    logic [127:0] fblk;
    cyc();
    bus.read_from_L2c_request = rd;
    bus.write_to_L2c_request = wr;
    bus.write_back_to_L2c_request = wbk;
    bus.cache_L2c_memory_address = a;
    bus.cache_1c_write_data_to_L2c = w;
    bus.write_back_to_L2c_data = b;
    cyc();
    t = wbk ? 2 : (wr ? 1 : 0);
    i = int'(a[7:4]);
    tg = a[29:8];
    h = 0;
    wy = 0;
    for (int k = 0; k < 2; k++)
      if (!h && m_valid[k][i] && m_tag[k][i] == tg) begin
        h = 1;
        wy = k[0];
      end
    exp_hit = h;
    exp_miss = !h;
    if (!h) begin
      if (!m_valid[0][i]) wy = 0;
      else if (!m_valid[1][i]) wy = 1;
      else wy = m_lru[i];
      if (m_valid[wy][i] && m_dirty[wy][i]) begin
        wa = {2'b00, m_tag[wy][i], i[3:0], 4'h0};
        nw = $urandom_range(0, 3);
        for (int k = 0; k <= nw; k++) begin
          cyc();
          exp_wb3 = 1;
          exp_addr3 = wa;
          exp_data3 = m_data[wy][i];
          if (k == nw) bus.write_back_to_L3_verified = 1;
          else bus.L3_ready = 1'($urandom_range(0, 1));
        end
        mem[wa] = m_data[wy][i];
        m_dirty[wy][i] = 0;
      end
      fa = {2'b00, a[29:4], 4'h0};
      fblk = mem_get(fa);
      nw = rstm ? 3 : $urandom_range(0, 3);
      for (int k = 0; k <= nw; k++) begin
        cyc();
        exp_rd3 = 1;
        exp_addr3 = fa;
        if (spur && k == 0) begin
          case ($urandom_range(0, 2))
            0: bus.read_from_L2c_request = 1;
            1: bus.write_to_L2c_request = 1;
            default: bus.write_back_to_L2c_request = 1;
          endcase
        end
        if (k == nw) begin
          if (rstm) reset = 1;
          else begin
            bus.L3_ready = 1;
            bus.read_data_from_L3 = fblk;
          end
        end else begin
          bus.write_back_to_L3_verified = 1'($urandom_range(0, 1));
        end
      end
      if (rstm) begin
        cyc();
        exp_blk = 0;
        model_reset();
        return;
      end
      m_valid[wy][i] = 1;
      m_tag[wy][i] = tg;
      m_data[wy][i] = fblk;
      m_dirty[wy][i] = 0;
    end
    cyc();
    case (t)
      0: begin
        exp_rdy = 1;
        exp_blk = m_data[wy][i];
      end
      1: begin
        exp_wv = 1;
        m_data[wy][i][a[3:2]*32 +: 32] = w;
        m_dirty[wy][i] = 1;
      end
      default: begin
        exp_wbv = 1;
        m_data[wy][i] = b;
        m_dirty[wy][i] = 1;
      end
    endcase
    m_lru[i] = !wy;
    cyc();
  endtask

  localparam logic [127:0] B1 =
    128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
  localparam logic [127:0] B2 =
    128'hDDDD_DDDD_1234_5678_BBBB_BBBB_AAAA_AAAA;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n0, n1;
    logic [1:0] pid, tgr, ixr, ofr;
    logic [31:0] a;
    int r;
    reset = 1;
    bus.read_from_L2c_request = 0;
    bus.write_to_L2c_request = 0;
    bus.write_back_to_L2c_request = 0;
    bus.cache_L2c_memory_address = 0;
    bus.cache_1c_write_data_to_L2c = 0;
    bus.write_back_to_L2c_data = 0;
    bus.L3_ready = 0;
    bus.read_data_from_L3 = 0;
    bus.write_back_to_L3_verified = 0;
    exp_hit = 0; exp_miss = 0; exp_rdy = 0; exp_wv = 0; exp_wbv = 0;
    exp_rd3 = 0; exp_wb3 = 0; exp_addr3 = 0; exp_data3 = 0; exp_blk = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    chk("rst_ready", bus.L2c_ready, 1'b0);
    chk("rst_l3_req", bus.read_from_L3_request, 1'b0);
    chk("rst_block", bus.write_data_to_L1c_from_L2c, 128'h0);

    mem[32'h0000_0100] = B1;
    n0 = n_miss;
    txn(1, 0, 0, 32'h8000_0104, 0, 0, 0, 0);
    chk("first_read_miss", 32'(n_miss - n0), 32'd1);
    chk("first_fetch_addr", obs_fetch, 32'h0000_0100);
    chk("first_block", obs_blk, B1);
    n0 = n_hit;
    txn(1, 0, 0, 32'h8000_0104, 0, 0, 0, 0);
    chk("reread_hit", 32'(n_hit - n0), 32'd1);

    txn(0, 1, 0, 32'h8000_0108, 32'h1234_5678, 0, 0, 0);
    txn(1, 0, 0, 32'h8000_0104, 0, 0, 0, 0);
    chk("merged_block", obs_blk, B2);

    txn(1, 0, 0, 32'h0000_1100, 0, 0, 0, 0);
    txn(1, 0, 0, 32'h0000_2100, 0, 0, 0, 0);
    chk("evict_addr", obs_wb, 32'h0000_0100);
    chk("evict_data", obs_wbdata, B2);
    chk("evict_before_fetch", 1'(last_wb_cyc < last_fetch_cyc), 1'b1);

    n0 = n_wbv;
    n1 = n_rdy;
    txn(1, 0, 1, 32'h0000_1100, 0, {4{32'h5A5A_0F0F}}, 0, 0);
    chk("prio_wb_pulse", 32'(n_wbv - n0), 32'd1);
    chk("prio_no_ready", 32'(n_rdy - n1), 32'd0);

    txn(1, 0, 0, 32'h0000_3100, 0, 0, 0, 1);
    n0 = n_miss;
    txn(1, 0, 0, 32'h0000_1100, 0, 0, 0, 0);
    chk("post_reset_miss", 32'(n_miss - n0), 32'd1);

    n0 = n_rdy + n_wv + n_wbv;
    txn(1, 0, 0, 32'h0000_4140, 0, 0, 1, 0);
    chk("one_completion", 32'(n_rdy + n_wv + n_wbv - n0), 32'd1);

    for (int k = 0; k < 250; k++) begin
      pid = 2'($urandom);
      tgr = 2'($urandom);
      ixr = 2'($urandom);
      ofr = 2'($urandom);
      a = {pid, 20'h0, tgr, 2'b00, ixr, ofr, 2'b00};
      r = $urandom_range(0, 9);
      txn(r < 5 || r == 8, r == 5 || r == 6 || r == 9,
          r == 7 || r == 8 || r == 9, a, $urandom,
          {$urandom, $urandom, $urandom, $urandom},
          $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
    end
    cyc();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_fsm_l2c.md
Name: cache_fsm_L2c

Overview:
- Level-2 cache controller directly downstream of the processor-C L1 controller (cache_fsm_L1c).
- Serves L1c block reads, inclusion-policy word writes, and dirty-block write-backs.
- 2-way set-associative, write-back, write-allocate, one LRU bit per set.
- Misses and dirty evictions go to the L3 stage over a request/verify handshake.

Parameters:
ADDRESS_WIDTH, 32, request address width; bits [31:30] are processor ID, ignored for lookup
DATA_WIDTH, 32, word width
BLOCK_WIDTH, 128, block width (4 words)
L2_NUM_SETS, 16, sets; INDEX_W = log2(L2_NUM_SETS)
OFFSET_LSB, 2, lowest word-offset bit; offset = addr[OFFSET_LSB+1:OFFSET_LSB], index = addr[INDEX_W+3:4], tag = addr[29:INDEX_W+4]

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
read_from_L2c_request  in  1  L1c block read
write_to_L2c_request  in  1  L1c word write (inclusion)
write_back_to_L2c_request  in  1  L1c dirty-block eviction
cache_L2c_memory_address  in  ADDRESS_WIDTH  request address
cache_1c_write_data_to_L2c  in  DATA_WIDTH  word for write request
write_back_to_L2c_data  in  BLOCK_WIDTH  block for write-back request
L2c_ready  out  1  read complete pulse
write_data_to_L1c_from_L2c  out  BLOCK_WIDTH  block returned to L1c
write_to_L2c_verified  out  1  word write complete pulse
write_back_to_L2c_verified  out  1  write-back complete pulse
L2c_cache_hit  out  1  hit pulse (COMPARE)
L2c_cache_miss  out  1  miss pulse (COMPARE)
read_from_L3_request  out  1  block fetch to L3
write_back_to_L3_request  out  1  dirty eviction to L3
cache_L3_memory_address  out  ADDRESS_WIDTH  L3 address
write_back_to_L3_data  out  BLOCK_WIDTH  evicted block
L3_ready  in  1  fetch done; data valid this cycle
read_data_from_L3  in  BLOCK_WIDTH  fetched block
write_back_to_L3_verified  in  1  eviction accepted

Behaviour:
- Reset (sync): state IDLE; all valid, dirty and LRU bits 0; every output 0; in-flight L3 request dropped without waiting.
- Request acceptance:
  - Each L1 request is accepted on its rising edge only (registered previous value), and only in IDLE.
  - Same-cycle rising edges are prioritised write_back > write > read; lower-priority edges are discarded.
  - Edges arriving outside IDLE are ignored.
  - On accept, address, word and block are latched.
- States: IDLE, COMPARE, WRITE_BACK_L3, ALLOCATE, RESPOND.
- IDLE -> COMPARE on accept.
- COMPARE (1 cycle): hit = valid & tag match in either way; pulse L2c_cache_hit or L2c_cache_miss.
  - Hit -> RESPOND. Miss with clean victim -> ALLOCATE. Miss with dirty victim -> WRITE_BACK_L3.
- Victim: invalid way0 first, then invalid way1, else the LRU way.
- WRITE_BACK_L3:
  - Hold write_back_to_L3_request=1; address = {2'b00, victim tag, index, 4'b0}; data = victim block.
  - On write_back_to_L3_verified: drop request, clear victim dirty bit -> ALLOCATE.
- ALLOCATE:
  - Hold read_from_L3_request=1; address = latched address with offset and byte bits zeroed.
  - On L3_ready: write read_data_from_L3 into victim way, set valid, tag, dirty=0 -> RESPOND.
- RESPOND (1 cycle), per accepted request type:
  - Read: write_data_to_L1c_from_L2c = way block; pulse L2c_ready.
  - Write: merge word at offset*DATA_WIDTH; dirty=1; pulse write_to_L2c_verified.
  - Write-back: replace whole block; dirty=1; pulse write_back_to_L2c_verified.
- RESPOND -> IDLE.
- LRU: set to the other way on every RESPOND for the accessed way.
- write_data_to_L1c_from_L2c holds its value until the next read RESPOND.
- Latency: hit response 2 cycles after accept (accept edge T, COMPARE T+1, pulse T+2). Clean miss: pulse 1 cycle after L3_ready. Dirty miss: adds the L3 write-back handshake.
- Verify pulses are exactly 1 cycle; at most one completion pulse per accept.
- L3 inputs are ignored outside their state. L3_ready and write_back_to_L3_verified asserted in the same cycle act only per the current state.

Test Plan:
- Reset, then read edge at 0x8000_0104 -> miss pulse; read_from_L3_request with address 0x0000_0100; L3_ready with 0xDDDD_CCCC_BBBB_AAAA_... -> L2c_ready 1 cycle later with the same block; re-read -> hit, L2c_ready exactly 2 cycles after edge.
- Write 0x1234_5678 to 0x8000_0108 after the above -> hit; read returns word 2 = 0x1234_5678, other words unchanged; set dirty.
- Three tags to index 0 (0x0000_0100, 0x0000_1100, 0x0000_2100, first dirty) -> third miss evicts the LRU first tag; write_back_to_L3 address 0x0000_0100 precedes read_from_L3.
- Write-back and read rising edges in the same cycle -> only write_back_to_L2c_verified pulses; read dropped, no L2c_ready.
- Reset asserted mid-ALLOCATE with L3 never responding -> next cycle IDLE, all outputs 0; a previously resident address now misses.
- Request edge while in ALLOCATE -> ignored; exactly one completion pulse for the original request.
